// File: rtl/axis_pkg.sv
// axis_pkg: shared state type and index-width helper for the AXI stream arbiter
package axis_pkg;

    typedef enum logic {ARB, PASS} arb_state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_register.sv
// axis_register: single-entry registered AXI stream stage carrying tlast, tdata and an id
module axis_register #(
    parameter int DATA_W = 8,
    parameter int ID_W   = 1
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    input  logic [DATA_W-1:0] s_data,
    input  logic [ID_W-1:0]   s_id,
    input  logic              m_ready,
    output logic              m_valid,
    output logic              m_last,
    output logic [DATA_W-1:0] m_data,
    output logic [ID_W-1:0]   m_id
);

    assign s_ready = !m_valid || m_ready;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            m_id    <= '0;
        end else if (s_valid && s_ready) begin
            m_valid <= 1'b1;
            m_last  <= s_last;
            m_data  <= s_data;
            m_id    <= s_id;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_rr_select.sv
// axis_rr_select: round-robin pick of the first requester at or after ptr, wrapping
module axis_rr_select #(
    parameter int NUM_STREAMS = 2,
    parameter int SEL_W       = 1
) (
    input  logic [NUM_STREAMS-1:0] req,
    input  logic [SEL_W-1:0]       ptr,
    output logic                   any_req,
    output logic [SEL_W-1:0]       grant
);

    int off;
    int best;

    // The winner is the requester with the smallest circular distance from ptr
    always_comb begin
        any_req = |req;
        grant   = '0;
        best    = NUM_STREAMS;
        off     = 0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            off = (i >= int'(ptr)) ? i - int'(ptr) : i - int'(ptr) + NUM_STREAMS;
            if (req[i] && off < best) begin
                best  = off;
                grant = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-level round-robin merge of NUM_STREAMS AXI streams into one tagged output
module axis_packet_arbiter
    import axis_pkg::*;
#(
    parameter  int AXIS_BYTES  = 1,
    parameter  int NUM_STREAMS = 2,
    localparam int SEL_W       = sel_width(NUM_STREAMS)
) (
    input  logic                             clk,
    input  logic                             areset,
    output logic [NUM_STREAMS-1:0]           axis_i_tready,
    input  logic [NUM_STREAMS-1:0]           axis_i_tvalid,
    input  logic [NUM_STREAMS-1:0]           axis_i_tlast,
    input  logic [NUM_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata,
    input  logic                             axis_o_tready,
    output logic                             axis_o_tvalid,
    output logic                             axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]          axis_o_tdata,
    output logic [SEL_W-1:0]                 axis_o_tid
);

    localparam int W = AXIS_BYTES * 8;

    arb_state_t       state, state_nx;
    logic [SEL_W-1:0] ptr, sel, grant;
    logic             any_req, out_ready, accept;
    logic             sel_valid, sel_last;
    logic [W-1:0]     sel_data;

    axis_rr_select #(.NUM_STREAMS(NUM_STREAMS), .SEL_W(SEL_W)) u_select (
        .req     (axis_i_tvalid),
        .ptr     (ptr),
        .any_req (any_req),
        .grant   (grant)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            state <= ARB;
        else
            state <= state_nx;
    end

    // ptr moves past the finished source so the next scan starts with its neighbour
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ptr <= '0;
            sel <= '0;
        end else begin
            if (state == ARB && any_req)
                sel <= grant;
            if (accept && sel_last)
                ptr <= (sel == SEL_W'(NUM_STREAMS - 1)) ? '0 : sel + 1'b1;
        end
    end

    always_comb begin
        state_nx = (state == ARB) ? (any_req ? PASS : ARB) : ((accept && sel_last) ? ARB : PASS);
    end

    always_comb begin
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        sel_data      = '0;
        axis_i_tready = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (SEL_W'(i) == sel) begin
                sel_valid = axis_i_tvalid[i];
                sel_last  = axis_i_tlast[i];
                sel_data  = axis_i_tdata[(i+1)*W-1 -: W];
            end
            axis_i_tready[i] = (state == PASS) && (SEL_W'(i) == sel) && out_ready;
        end
        accept = (state == PASS) && sel_valid && out_ready;
    end

    axis_register #(.DATA_W(W), .ID_W(SEL_W)) u_out (
        .clk     (clk),
        .areset  (areset),
        .s_valid ((state == PASS) && sel_valid),
        .s_ready (out_ready),
        .s_last  (sel_last),
        .s_data  (sel_data),
        .s_id    (sel),
        .m_ready (axis_o_tready),
        .m_valid (axis_o_tvalid),
        .m_last  (axis_o_tlast),
        .m_data  (axis_o_tdata),
        .m_id    (axis_o_tid)
    );

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: randomized scenarios against a packet-level round-robin reference model
module tb_axis_packet_arbiter;

    typedef struct packed {logic l; logic [7:0] d;} beat_t;
    typedef struct packed {logic [1:0] id; logic l; logic [7:0] d;} obs_t;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  i_tvalid, i_tlast;
    logic [31:0] i_tdata;
    logic [3:0]  i_tready;
    logic        o_tready, o_tvalid, o_tlast;
    logic [7:0]  o_tdata;
    logic [1:0]  o_tid;

    logic        s_tvalid, s_tlast, s_tready, s_o_tready;
    logic [7:0]  s_tdata;
    logic        d1_tvalid, d1_tlast;
    logic [7:0]  d1_tdata;
    logic [0:0]  d1_tid;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    rdy_mode = 0;
    beat_t q [4][$];
    obs_t  obs_q[$];
    obs_t  exp_q[$];

    axis_packet_arbiter #(.AXIS_BYTES(1), .NUM_STREAMS(4)) dut (
        .clk(clk), .areset(areset),
        .axis_i_tready(i_tready), .axis_i_tvalid(i_tvalid), .axis_i_tlast(i_tlast), .axis_i_tdata(i_tdata),
        .axis_o_tready(o_tready), .axis_o_tvalid(o_tvalid), .axis_o_tlast(o_tlast), .axis_o_tdata(o_tdata),
        .axis_o_tid(o_tid)
    );

    axis_packet_arbiter #(.AXIS_BYTES(1), .NUM_STREAMS(1)) dut1 (
        .clk(clk), .areset(areset),
        .axis_i_tready(s_tready), .axis_i_tvalid(s_tvalid), .axis_i_tlast(s_tlast), .axis_i_tdata(s_tdata),
        .axis_o_tready(s_o_tready), .axis_o_tvalid(d1_tvalid), .axis_o_tlast(d1_tlast), .axis_o_tdata(d1_tdata),
        .axis_o_tid(d1_tid)
    );

    always #5 clk = ~clk;

    task automatic present();
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0) begin
                i_tvalid[i]       = 1'b1;
                i_tlast[i]        = q[i][0].l;
                i_tdata[i*8 +: 8] = q[i][0].d;
            end else begin
                i_tvalid[i]       = 1'b0;
                i_tlast[i]        = 1'($urandom_range(0, 1));
                i_tdata[i*8 +: 8] = 8'($urandom);
            end
        end
    endtask

    task automatic add_pkt(input int i, input int len);
        for (int b = 0; b < len; b++)
            q[i].push_back('{l: (b == len - 1), d: 8'($urandom)});
    endtask

    task automatic tick(output logic ov, output logic ordy, output logic [3:0] tr);
        logic [3:0] hs;
        @(negedge clk);
        hs   = i_tvalid & i_tready;
        ov   = o_tvalid;
        ordy = o_tready;
        tr   = i_tready;
        if (o_tvalid && o_tready)
            obs_q.push_back('{id: o_tid, l: o_tlast, d: o_tdata});
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (hs[i]) void'(q[i].pop_front());
        present();
        cyc++;
        o_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
    endtask

    task automatic step();
        logic a, b;
        logic [3:0] c;
        tick(a, b, c);
    endtask

    task automatic drain(input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            step();
            k++;
        end
        repeat (4) step();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        for (int i = 0; i < 4; i++) q[i].delete();
        obs_q.delete();
        exp_q.delete();
        present();
        s_tvalid = 1'b0;
        o_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b0;
        cyc = 0;
    endtask

    // Reference: whole packets in round-robin order over the queued sources, starting the scan at p
    function automatic void build_exp(input int p);
        beat_t c [4][$];
        beat_t b;
        int    i;
        for (int k = 0; k < 4; k++) c[k] = q[k];
        exp_q.delete();
        while (1) begin
            i = -1;
            for (int off = 0; off < 4; off++)
                if (i < 0 && c[(p + off) % 4].size() > 0) i = (p + off) % 4;
            if (i < 0) break;
            do begin
                b = c[i].pop_front();
                exp_q.push_back('{id: 2'(i), l: b.l, d: b.d});
            end while (!b.l);
            p = (i + 1) % 4;
        end
    endfunction

    task automatic test_reset();
        do_reset();
        total++; if (o_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", o_tvalid); end
        total++; if (o_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b want=0", o_tlast); end
        total++; if (o_tdata !== 8'h00) begin bad++; $display("FAIL reset_tdata got=%h want=00", o_tdata); end
        total++; if (o_tid !== 2'd0) begin bad++; $display("FAIL reset_tid got=%0d want=0", o_tid); end
        total++; if (i_tready !== 4'b0) begin bad++; $display("FAIL reset_tready got=%b want=0000", i_tready); end
        total++; if (d1_tvalid !== 1'b0 || s_tready !== 1'b0) begin bad++; $display("FAIL reset_n1 got=%b%b want=00", d1_tvalid, s_tready); end
    endtask

    task automatic test_single_packet();
        logic ov, ordy;
        logic [3:0] tr;
        int n = 0;
        do_reset();
        rdy_mode = 0;
        add_pkt(2, 3);
        build_exp(0);
        present();
        ov = 1'b0;
        while (!ov && n < 20) begin
            tick(ov, ordy, tr);
            n++;
        end
        total++; if (n - 1 != 2) begin bad++; $display("FAIL single_latency got=%0d want=2", n - 1); end
        drain(3, 50);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL single_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            total++; if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL single_beat%0d got=%h want=%h", k, obs_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_round_robin();
        int n = 0, prev = -1, sz;
        do_reset();
        rdy_mode = 0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) add_pkt(i, 1);
        build_exp(0);
        present();
        while (obs_q.size() < 8 && n < 100) begin
            sz = obs_q.size();
            step();
            n++;
            if (obs_q.size() > sz) begin
                if (prev >= 0) begin
                    total++; if (n - prev != 2) begin bad++; $display("FAIL rr_gap got=%0d want=2", n - prev); end
                end
                prev = n;
            end
        end
        drain(8, 10);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rr_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            total++; if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL rr_beat%0d got=%h want=%h", k, obs_q[k], exp_q[k]); end
            total++; if (obs_q[k].id !== 2'(k % 4)) begin bad++; $display("FAIL rr_order%0d got=%0d want=%0d", k, obs_q[k].id, k % 4); end
        end
    endtask

    task automatic test_no_interleave();
        logic ov, ordy;
        logic [3:0] tr;
        beat_t cp1[$], cp0[$];
        int n = 0;
        do_reset();
        rdy_mode = 0;
        add_pkt(1, 5);
        cp1 = q[1];
        present();
        while (q[1].size() > 0 && n < 100) begin
            if (q[1].size() == 3 && q[0].size() == 0) begin
                add_pkt(0, 2);
                cp0 = q[0];
                present();
            end
            tick(ov, ordy, tr);
            n++;
            total++; if (tr[0] !== 1'b0) begin bad++; $display("FAIL hold_tready0 got=%b want=0 cycle=%0d", tr[0], n); end
        end
        foreach (cp1[k]) exp_q.push_back('{id: 2'd1, l: cp1[k].l, d: cp1[k].d});
        foreach (cp0[k]) exp_q.push_back('{id: 2'd0, l: cp0[k].l, d: cp0[k].d});
        drain(7, 50);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL hold_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            total++; if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL hold_beat%0d got=%h want=%h", k, obs_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_backpressure();
        logic ov, ordy;
        logic [3:0] tr;
        int n = 0;
        do_reset();
        rdy_mode = 2;
        add_pkt(3, 8);
        build_exp(0);
        present();
        while (obs_q.size() < 8 && n < 200) begin
            tick(ov, ordy, tr);
            n++;
            if (ov && !ordy) begin
                total++; if (tr[3] !== 1'b0) begin bad++; $display("FAIL bp_tready3 got=%b want=0 cycle=%0d", tr[3], n); end
            end
        end
        drain(8, 10);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            total++; if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL bp_beat%0d got=%h want=%h", k, obs_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        do_reset();
        rdy_mode = 0;
        add_pkt(2, 1);
        present();
        drain(1, 20);
        add_pkt(2, 6);
        present();
        while (q[2].size() > 3 && n < 50) begin
            step();
            n++;
        end
        total++; if (o_tvalid !== 1'b1) begin bad++; $display("FAIL ar_pre_tvalid got=%b want=1", o_tvalid); end
        #2;
        areset = 1'b1;
        #1;
        total++; if (o_tvalid !== 1'b0 || o_tlast !== 1'b0) begin bad++; $display("FAIL ar_async_out got=%b%b want=00", o_tvalid, o_tlast); end
        total++; if (o_tdata !== 8'h00 || o_tid !== 2'd0) begin bad++; $display("FAIL ar_async_data got=%h/%0d want=00/0", o_tdata, o_tid); end
        total++; if (i_tready !== 4'b0) begin bad++; $display("FAIL ar_async_tready got=%b want=0000", i_tready); end
        for (int i = 0; i < 4; i++) q[i].delete();
        present();
        @(posedge clk);
        #1;
        areset = 1'b0;
        obs_q.delete();
        add_pkt(3, 2);
        add_pkt(1, 2);
        build_exp(0);
        present();
        drain(4, 50);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL ar_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            total++; if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL ar_beat%0d got=%h want=%h", k, obs_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_random();
        int beats;
        for (int it = 0; it < 20; it++) begin
            do_reset();
            rdy_mode = 1;
            beats = 0;
            for (int i = 0; i < 4; i++)
                for (int p = $urandom_range(0, 3); p > 0; p--) begin
                    int len = $urandom_range(1, 4);
                    add_pkt(i, len);
                    beats += len;
                end
            build_exp(0);
            present();
            drain(beats, 400);
            total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", it, obs_q.size(), exp_q.size()); end
            for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
                total++; if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL rnd%0d_beat%0d got=%h want=%h", it, k, obs_q[k], exp_q[k]); end
            end
        end
    endtask

    task automatic test_single_stream();
        beat_t sent[$];
        obs_t  got[$];
        int    bc = 0, win = 0;
        logic  hs;
        do_reset();
        s_o_tready = 1'b1;
        s_tvalid   = 1'b1;
        s_tdata    = 8'($urandom);
        s_tlast    = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            hs = s_tvalid && s_tready;
            if (hs) sent.push_back('{l: s_tlast, d: s_tdata});
            if (d1_tvalid) begin
                got.push_back('{id: {1'b0, d1_tid}, l: d1_tlast, d: d1_tdata});
                if (c >= 20 && c < 40) win++;
            end
            @(posedge clk);
            #1;
            if (hs) begin
                bc      = (bc + 1) % 4;
                s_tdata = 8'($urandom);
                s_tlast = (bc == 3);
            end
        end
        total++; if (win != 16) begin bad++; $display("FAIL n1_rate got=%0d want=16", win); end
        total++; if (got.size() + 1 < sent.size() || got.size() > sent.size()) begin bad++; $display("FAIL n1_count got=%0d want=%0d", got.size(), sent.size()); end
        for (int k = 0; k < got.size() && k < sent.size(); k++) begin
            total++;
            if (got[k] !== '{id: 2'd0, l: (k % 4 == 3), d: sent[k].d}) begin
                bad++; $display("FAIL n1_beat%0d got=%h want=id0 last=%0d d=%h", k, got[k], (k % 4 == 3), sent[k].d);
            end
        end
        s_tvalid = 1'b0;
    endtask

    initial begin
        areset     = 1'b1;
        o_tready   = 1'b1;
        s_o_tready = 1'b1;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        s_tdata    = 8'h00;
        i_tvalid   = 4'b0;
        i_tlast    = 4'b0;
        i_tdata    = 32'h0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_no_interleave();
        test_backpressure();
        test_async_reset();
        test_random();
        test_single_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
